// File: rtl/cgra_sram_bank_ctrl.sv
// Round-robin front end for one single-port CGRA SRAM bank, with idle-driven retention control.
// Latency: grant is combinational in the request cycle; response valid follows one cycle later.
// Backpressure: a requester holds req/payload until gnt; nothing is granted in RETENTIVE or WAKE.
module cgra_sram_bank_ctrl #(
    parameter int unsigned NumPorts   = 4,
    parameter int unsigned NumWords   = 1024,
    parameter int unsigned IdleCycles = 16,
    parameter int unsigned WakeCycles = 2,
    parameter int unsigned AddrWidth  = (NumWords > 1) ? $clog2(NumWords) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumPorts-1:0]           port_req_i,
    input  logic [NumPorts-1:0]           port_we_i,
    input  logic [NumPorts*AddrWidth-1:0] port_addr_i,
    input  logic [NumPorts*32-1:0]        port_wdata_i,
    input  logic [NumPorts*4-1:0]         port_be_i,
    output logic [NumPorts-1:0]           port_gnt_o,
    output logic [NumPorts-1:0]           port_rvalid_o,
    output logic [NumPorts*32-1:0]        port_rdata_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [AddrWidth-1:0]          mem_addr_o,
    output logic [31:0]                   mem_wdata_o,
    output logic [3:0]                    mem_be_o,
    output logic                          mem_set_retentive_o,
    input  logic [31:0]                   mem_rdata_i,
    input  logic                          retention_en_i,
    output logic                          retentive_o
);

    localparam int unsigned PtrW  = $clog2(NumPorts);
    localparam int unsigned IdleW = $clog2(IdleCycles + 1);
    localparam int unsigned WakeW = (WakeCycles > 1) ? $clog2(WakeCycles) : 1;

    localparam logic [IdleW-1:0] IdleMax  = IdleW'(IdleCycles);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(IdleCycles - 1);
    localparam logic [WakeW-1:0] WakeLast = WakeW'(WakeCycles - 1);
    localparam logic [PtrW-1:0]  PtrLast  = PtrW'(NumPorts - 1);

    typedef enum logic [1:0] {
        ST_ACTIVE    = 2'd0,
        ST_RETENTIVE = 2'd1,
        ST_WAKE      = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
    logic [WakeW-1:0] wake_cnt_q, wake_cnt_d;
    logic             rvalid_q;
    logic [PtrW-1:0]  resp_port_q;

    logic             any_req;
    logic             win_found;
    logic [PtrW-1:0]  win_idx;
    logic             grant_en;

    assign any_req  = |port_req_i;
    assign grant_en = (state_q == ST_ACTIVE) && win_found;

    // Round-robin scan: first requester at or above the pointer, wrapping around.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NumPorts) begin
                idx = idx - NumPorts;
            end
            if (!win_found && port_req_i[idx]) begin
                win_found = 1'b1;
                win_idx   = PtrW'(idx);
            end
        end
    end

    // Steer the winner's payload to the bank; bank side idles at zero otherwise.
    always_comb begin
        port_gnt_o  = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (grant_en) begin
            port_gnt_o[win_idx] = 1'b1;
            mem_req_o           = 1'b1;
            mem_we_o            = port_we_i[win_idx];
            mem_addr_o          = port_addr_i[32'(win_idx)*AddrWidth +: AddrWidth];
            mem_wdata_o         = port_wdata_i[32'(win_idx)*32 +: 32];
            mem_be_o            = port_be_i[32'(win_idx)*4 +: 4];
        end
    end

    // Response valid is one-hot on the port granted in the previous cycle.
    always_comb begin
        port_rvalid_o = '0;
        if (rvalid_q) begin
            port_rvalid_o[resp_port_q] = 1'b1;
        end
    end

    // Read data is broadcast; only the port with rvalid consumes it.
    assign port_rdata_o = {NumPorts{mem_rdata_i}};

    assign mem_set_retentive_o = (state_q == ST_RETENTIVE);
    assign retentive_o         = (state_q == ST_RETENTIVE);

    // Next-state logic: pointer advance, idle/wake counting and retention transitions.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;

        if (grant_en) begin
            rr_ptr_d = (win_idx == PtrLast) ? '0 : PtrW'(win_idx + 1'b1);
        end

        case (state_q)
            ST_ACTIVE: begin
                if (any_req) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q != IdleMax) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
                // An in-flight response must land before the bank is put to sleep.
                if ((idle_cnt_q == IdleLast) && !any_req && retention_en_i && !rvalid_q) begin
                    state_d = ST_RETENTIVE;
                end
            end
            ST_RETENTIVE: begin
                if (any_req || !retention_en_i) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = '0;
                end
            end
            ST_WAKE: begin
                if (wake_cnt_q == WakeLast) begin
                    state_d    = ST_ACTIVE;
                    idle_cnt_d = '0;
                    wake_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_ACTIVE;
            end
        endcase
    end

    // State, pointer and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_ACTIVE;
            rr_ptr_q   <= '0;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
        end
    end

    // Response tracking: every grant, read or write, produces one rvalid next cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q    <= 1'b0;
            resp_port_q <= '0;
        end else begin
            rvalid_q <= grant_en;
            if (grant_en) begin
                resp_port_q <= win_idx;
            end
        end
    end

endmodule
